// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped read-only data cache.
package cache_pkg;

  localparam int ADR_W  = 15;
  localparam int WORD_W = 32;
  localparam int IDX_W  = 8;
  localparam int OFF_W  = 2;
  localparam int TAG_W  = ADR_W - IDX_W - OFF_W;
  localparam int NLINES = 1 << IDX_W;
  localparam int NWORDS = 1 << OFF_W;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FILL
  } state_e;

  typedef logic [NWORDS-1:0][WORD_W-1:0] block_t;

  function automatic logic [TAG_W-1:0] tag_of(
    input logic [ADR_W-1:0] a
  );
    return a[ADR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(
    input logic [ADR_W-1:0] a
  );
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] off_of(
    input logic [ADR_W-1:0] a
  );
    return a[OFF_W-1:0];
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// CPU load port and memory refill bus of the data cache.
interface dcache_ctrl_if;
  import cache_pkg::*;

  logic              cpu_rd;
  logic [ADR_W-1:0]  cpu_adr;
  logic [WORD_W-1:0] cpu_data;
  logic              cpu_rdy;
  logic              mem_read;
  logic [ADR_W-1:0]  mem_adr;
  block_t            mem_data;
  logic              mem_rdy;

  modport slave (
    input  cpu_rd, cpu_adr, mem_data, mem_rdy,
    output cpu_data, cpu_rdy, mem_read, mem_adr
  );

  modport master (
    output cpu_rd, cpu_adr, mem_data, mem_rdy,
    input  cpu_data, cpu_rdy, mem_read, mem_adr
  );

endinterface

// File: rtl/cache_line_store.sv
// Tag, valid and data arrays; combinational read, single write port.
module cache_line_store
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output block_t           rd_block_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  block_t           wr_block_i
);

  logic [NLINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q [NLINES];
  block_t            data_q [NLINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_block_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_block_o = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped read-only cache controller, IDLE/LOOKUP/FILL FSM.
// Optional hit/access counters enabled by CACHE_STATS_EN.
module dcache_ctrl
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
`ifdef CACHE_STATS_EN
  output logic [15:0] hit_count,
  output logic [15:0] access_count,
`endif
  dcache_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [WORD_W-1:0] cpu_data_q, cpu_data_d;
  logic              cpu_rdy_q, cpu_rdy_d;
  logic              mem_read_q, mem_read_d;
  logic [ADR_W-1:0]  mem_adr_q, mem_adr_d;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  block_t           rd_block;
  logic             lookup;
  logic             hit;
  logic             miss;
  logic             fill_done;
  logic             we;

  assign lookup    = state_q == LOOKUP;
  assign hit       = lookup && rd_valid
                   && (rd_tag == tag_of(adr_q));
  assign miss      = lookup && !hit;
  assign fill_done = (state_q == FILL) && bus.mem_rdy;
  // A reset edge during FILL must not commit the line.
  assign we        = fill_done && !rst;

  cache_line_store u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (idx_of(adr_q)),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_block_o (rd_block),
    .we_i       (we),
    .wr_idx_i   (idx_of(adr_q)),
    .wr_tag_i   (tag_of(adr_q)),
    .wr_block_i (bus.mem_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      cpu_data_q <= '0;
      cpu_rdy_q  <= 1'b0;
      mem_read_q <= 1'b0;
      mem_adr_q  <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      cpu_data_q <= cpu_data_d;
      cpu_rdy_q  <= cpu_rdy_d;
      mem_read_q <= mem_read_d;
      mem_adr_q  <= mem_adr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_rd) begin
          state_d = LOOKUP;
          adr_d   = bus.cpu_adr;
        end
      end
      LOOKUP: state_d = hit ? IDLE : FILL;
      FILL:   state_d = bus.mem_rdy ? IDLE : FILL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_rdy_d  = hit || fill_done;
    cpu_data_d = cpu_data_q;
    mem_read_d = miss || ((state_q == FILL) && !bus.mem_rdy);
    mem_adr_d  = mem_adr_q;
    unique case (1'b1)
      hit:       cpu_data_d = rd_block[off_of(adr_q)];
      fill_done: cpu_data_d = bus.mem_data[off_of(adr_q)];
      default:   cpu_data_d = cpu_data_q;
    endcase
    if (miss) begin
      mem_adr_d = {tag_of(adr_q), idx_of(adr_q), {OFF_W{1'b0}}};
    end
  end

  assign bus.cpu_data = cpu_data_q;
  assign bus.cpu_rdy  = cpu_rdy_q;
  assign bus.mem_read = mem_read_q;
  assign bus.mem_adr  = mem_adr_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] acc_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
      acc_cnt_q <= '0;
    end else begin
      if (lookup) acc_cnt_q <= acc_cnt_q + 16'd1;
      if (hit)    hit_cnt_q <= hit_cnt_q + 16'd1;
    end
  end

  assign hit_count    = hit_cnt_q;
  assign access_count = acc_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl; memory[i]=i, mem_rdy 4 cycles after mem_read.
module tb_dcache_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   mr_cnt = 0;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] access_count;
`endif

  dcache_ctrl_if bus ();

  dcache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
`ifdef CACHE_STATS_EN
    .hit_count    (hit_count),
    .access_count (access_count),
`endif
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NWORDS; k++) begin
      bus.mem_data[k] = WORD_W'(bus.mem_adr) + WORD_W'(k);
    end
  end

  // mem_rdy rises on the 4th cycle of mem_read, drops right after it falls
  always @(negedge clk) begin
    if (bus.mem_read) begin
      mr_cnt = mr_cnt + 1;
      bus.mem_rdy = (mr_cnt >= 4);
    end else begin
      mr_cnt = 0;
      bus.mem_rdy = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic rd(input logic [ADR_W-1:0] a, input bit exp_miss,
                    input logic [31:0] exp_data, input bit hold);
    int lat = 0;
    bit got = 0;
    bit saw = 0;
    logic [ADR_W-1:0] madr = '0;
    bus.cpu_rd  = 1'b1;
    bus.cpu_adr = a;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!hold) bus.cpu_rd = 1'b0;
      if (bus.mem_read) begin
        saw  = 1;
        madr = bus.mem_adr;
      end
      if (bus.cpu_rdy) got = 1;
    end
    chk($sformatf("rdy_%h", a), 32'(got), 32'd1);
    chk($sformatf("data_%h", a), bus.cpu_data, exp_data);
    chk($sformatf("miss_%h", a), 32'(saw), 32'(exp_miss));
    chk($sformatf("mr_low_%h", a), 32'(bus.mem_read), 32'd0);
    if (exp_miss) begin
      chk($sformatf("madr_%h", a), 32'(madr),
          32'({a[ADR_W-1:2], 2'b00}));
    end else begin
      chk($sformatf("lat_%h", a), lat, 32'd2);
    end
    if (!hold) begin
      @(negedge clk);
      chk($sformatf("pulse_%h", a), 32'(bus.cpu_rdy), 32'd0);
    end
  endtask

  initial begin
    int w;
    bus.cpu_rd  = 1'b0;
    bus.cpu_adr = '0;
    bus.mem_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(bus.cpu_rdy), 32'd0);
    chk("rst_data", bus.cpu_data, 32'd0);
    chk("rst_mr", 32'(bus.mem_read), 32'd0);
    chk("rst_madr", 32'(bus.mem_adr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    rd(15'h0005, 1, 32'h5, 0);
    rd(15'h0006, 0, 32'h6, 0);
    rd(15'h0405, 1, 32'h405, 0);
    rd(15'h0005, 1, 32'h5, 0);
`ifdef CACHE_STATS_EN
    chk("acc_cnt", 32'(access_count), 32'd4);
    chk("hit_cnt", 32'(hit_count), 32'd1);
`endif

    // Reset in the middle of the 0x0100 refill
    bus.cpu_rd  = 1'b1;
    bus.cpu_adr = 15'h0100;
    w = 0;
    while (!bus.mem_read && w < 10) begin
      @(negedge clk);
      bus.cpu_rd = 1'b0;
      w++;
    end
    chk("fill_mr_seen", 32'(bus.mem_read), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("fill_rst_mr", 32'(bus.mem_read), 32'd0);
    chk("fill_rst_rdy", 32'(bus.cpu_rdy), 32'd0);
`ifdef CACHE_STATS_EN
    chk("rst_acc_cnt", 32'(access_count), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(15'h0100, 1, 32'h100, 0);
    rd(15'h0005, 1, 32'h5, 0);

    rd(15'h0404, 1, 32'h404, 0);
    rd(15'h0004, 1, 32'h4, 1);
    rd(15'h0007, 0, 32'h7, 0);
    rd(15'h0103, 0, 32'h103, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
